// File: rtl/dmem_responder_pkg.sv
// Shared types and RISC-V load/store funct3 encodings for the data-memory responder.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    DM_IDLE,
    DM_WAIT,
    DM_EXEC,
    DM_RESP
  } dmem_state_e;

  localparam logic [2:0] FUNCT3_LB  = 3'd0;
  localparam logic [2:0] FUNCT3_LH  = 3'd1;
  localparam logic [2:0] FUNCT3_LW  = 3'd2;
  localparam logic [2:0] FUNCT3_LBU = 3'd4;
  localparam logic [2:0] FUNCT3_LHU = 3'd5;
  localparam logic [2:0] FUNCT3_SB  = 3'd0;
  localparam logic [2:0] FUNCT3_SH  = 3'd1;
  localparam logic [2:0] FUNCT3_SW  = 3'd2;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores, extraction/extension for loads, and
// misalignment / illegal-funct3 detection. Purely combinational.
module dmem_lane_align
  import dmem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    we,
  input  logic [2:0]              funct3,
  input  logic [1:0]              addr_lo,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH-1:0]   rword,
  output logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   wdata_lane,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    bad
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int SH_W = $clog2(DATA_WIDTH);

  logic [SH_W-1:0]       sh;
  logic [DATA_WIDTH-1:0] rshift;

  assign sh     = SH_W'({addr_lo, 3'b000});
  assign rshift = rword >> sh;

  always_comb begin
    be         = '0;
    wdata_lane = '0;
    rdata      = '0;
    bad        = 1'b0;
    if (we) begin
      case (funct3)
        FUNCT3_SB: begin
          be         = BE_W'(1) << addr_lo;
          wdata_lane = DATA_WIDTH'(wdata[7:0]) << sh;
        end
        FUNCT3_SH: begin
          be         = BE_W'(3) << {addr_lo[1], 1'b0};
          wdata_lane = DATA_WIDTH'(wdata[15:0]) << sh;
          bad        = addr_lo[0];
        end
        FUNCT3_SW: begin
          be         = '1;
          wdata_lane = wdata;
          bad        = (addr_lo != 2'b00);
        end
        default: bad = 1'b1;
      endcase
    end else begin
      case (funct3)
        FUNCT3_LB:  rdata = {{(DATA_WIDTH-8){rshift[7]}}, rshift[7:0]};
        FUNCT3_LBU: rdata = {{(DATA_WIDTH-8){1'b0}}, rshift[7:0]};
        FUNCT3_LH: begin
          rdata = {{(DATA_WIDTH-16){rshift[15]}}, rshift[15:0]};
          bad   = addr_lo[0];
        end
        FUNCT3_LHU: begin
          rdata = {{(DATA_WIDTH-16){1'b0}}, rshift[15:0]};
          bad   = addr_lo[0];
        end
        FUNCT3_LW: begin
          rdata = rshift;
          bad   = (addr_lo != 2'b00);
        end
        default: bad = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: one outstanding request, programmable wait states,
// sized/extended loads, byte-enabled stores, and alignment/range error reporting.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  dmem_state_e           state;
  logic [CNT_W-1:0]      cnt;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic [BE_W-1:0]       be;
  logic [DATA_WIDTH-1:0] wdata_lane;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  lane_bad;
  logic                  range_bad;
  logic                  err;
  logic                  mem_we;

  assign idx       = addr_q[ADDR_WIDTH+1:2];
  assign range_bad = |addr_q[DATA_WIDTH-1:ADDR_WIDTH+2];
  assign err       = lane_bad | range_bad;
  assign mem_we    = (state == DM_EXEC) && we_q && !err;

  dmem_lane_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .we        (we_q),
    .funct3    (funct3_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rword     (mem[idx]),
    .be        (be),
    .wdata_lane(wdata_lane),
    .rdata     (ld_data),
    .bad       (lane_bad)
  );

  // Array has no reset; a reset landing on the EXEC edge may or may not commit the write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wdata_lane[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= DM_IDLE;
      cnt         <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      case (state)
        DM_IDLE: begin
          if (req_valid_i) begin
            we_q        <= req_we_i;
            funct3_q    <= req_funct3_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            req_ready_o <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              cnt   <= CNT_LOAD;
              state <= DM_WAIT;
            end else begin
              state <= DM_EXEC;
            end
          end
        end
        DM_WAIT: begin
          if (cnt == '0) state <= DM_EXEC;
          else           cnt   <= cnt - 1'b1;
        end
        DM_EXEC: begin
          rsp_rdata_o <= (err || we_q) ? '0 : ld_data;
          rsp_err_o   <= err;
          rsp_valid_o <= 1'b1;
          state       <= DM_RESP;
        end
        DM_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= DM_IDLE;
          end
        end
        default: state <= DM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responder instances (2 and 0 wait states) driven from
// one sequence; expected responses come from a byte-level memory model.
module tb_dmem_responder;

  localparam int W0 = 2;
  localparam int W1 = 0;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          acc;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  logic [31:0] model [2][1024];
  exp_t        sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_CYCLES(W0)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_funct3_i(req_funct3[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
  );

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_CYCLES(W1)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_funct3_i(req_funct3[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: decides error, produces load result, applies stores.
  task automatic predict(input int i, input bit we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err);
    logic [31:0] w;
    int          lo;
    int          wi;
    err = (a[31:12] != 20'h0);
    if (we) err = err || (f3 > 3'd2);
    else    err = err || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    if (f3[1:0] == 2'd1) err = err || a[0];
    if (f3[1:0] == 2'd2) err = err || (a[1:0] != 2'b00);
    rd = 32'h0;
    if (err) return;
    wi = int'(a[11:2]);
    w  = model[i][wi];
    lo = int'(a[1:0]) * 8;
    if (we) begin
      case (f3)
        3'd0:    model[i][wi][lo +: 8] = wd[7:0];
        3'd1:    model[i][wi][(a[1] ? 16 : 0) +: 16] = wd[15:0];
        default: model[i][wi] = wd;
      endcase
    end else begin
      case (f3)
        3'd0:    rd = {{24{w[lo+7]}}, w[lo +: 8]};
        3'd4:    rd = {24'h0, w[lo +: 8]};
        3'd1:    rd = {{16{w[(a[1] ? 31 : 15)]}}, w[(a[1] ? 16 : 0) +: 16]};
        3'd5:    rd = {16'h0, w[(a[1] ? 16 : 0) +: 16]};
        default: rd = w;
      endcase
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(sb.size()), 0);
    sb.delete();
  endtask

  task automatic txn(input int i, input bit we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input bit lat, input bit do_drain, output logic [31:0] rd_exp);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    req_valid[i]  = 1'b1;
    req_we[i]     = we;
    req_funct3[i] = f3;
    req_addr[i]   = a;
    req_wdata[i]  = wd;
    while (req_ready[i] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(n >= 50), 0);
    predict(i, we, f3, a, wd, e.rdata, e.err);
    e.inst = i;
    e.acc  = cyc + 1;
    e.lat  = lat;
    rd_exp = e.rdata;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
    if (do_drain) drain();
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (!rst && rsp_valid[i] && rsp_ready[i]) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid[i]), 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_inst", 32'(i), 32'(e.inst));
          chk("rdata", rsp_rdata[i], e.rdata);
          chk("err", 32'(rsp_err[i]), 32'(e.err));
          if (e.lat) chk("latency", 32'(cyc + 1 - e.acc), 32'((i == 0) ? W0 + 2 : W1 + 2));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx;
    logic [2:0]  lf [5];
    logic [2:0]  sf [3];
    int          n;
    lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    sf = '{3'd0, 3'd1, 3'd2};
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_funct3[i] = 3'd0;
      req_addr[i] = 32'h0; req_wdata[i] = 32'h0; rsp_ready[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready", 32'(req_ready[i]), 1);
      chk("rst_rsp_valid", 32'(rsp_valid[i]), 0);
      chk("rst_rdata", rsp_rdata[i], 0);
      chk("rst_err", 32'(rsp_err[i]), 0);
    end
    rst = 1'b0;

    txn(0, 1, 3'd2, 32'h0,  32'h12345678, 1, 1, rx);
    txn(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 1, 1, rx);
    txn(0, 0, 3'd2, 32'h10, 32'h0,        1, 1, rx);
    txn(0, 1, 3'd0, 32'h11, 32'h00000055, 1, 1, rx);
    txn(0, 0, 3'd2, 32'h10, 32'h0,        1, 1, rx);
    txn(0, 0, 3'd0, 32'h13, 32'h0,        1, 1, rx);
    txn(0, 0, 3'd4, 32'h13, 32'h0,        1, 1, rx);
    txn(0, 0, 3'd1, 32'h12, 32'h0,        1, 1, rx);
    txn(0, 0, 3'd5, 32'h10, 32'h0,        1, 1, rx);

    // error cases; memory contents are re-read afterwards
    txn(0, 0, 3'd2, 32'h12,   32'h0,        1, 1, rx);
    txn(0, 1, 3'd1, 32'h11,   32'h0000FFFF, 1, 1, rx);
    txn(0, 0, 3'd3, 32'h10,   32'h0,        1, 1, rx);
    txn(0, 1, 3'd2, 32'h1000, 32'hFFFFFFFF, 1, 1, rx);
    txn(0, 1, 3'd5, 32'h10,   32'hFFFFFFFF, 1, 1, rx);
    txn(0, 0, 3'd2, 32'h10,   32'h0,        1, 1, rx);
    txn(0, 0, 3'd2, 32'h0,    32'h0,        1, 1, rx);

    // backpressure
    rsp_ready[0] = 1'b0;
    txn(0, 0, 3'd2, 32'h10, 32'h0, 0, 0, rx);
    n = 0;
    while (rsp_valid[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_wait", 32'(n >= 20), 0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid[0]), 1);
      chk("bp_rdata", rsp_rdata[0], rx);
      chk("bp_req_ready", 32'(req_ready[0]), 0);
    end
    @(posedge clk);
    #1 rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1 chk("bp_ready_after", 32'(req_ready[0]), 1);
    drain();

    // randomized sized accesses over a pre-initialised window
    for (int k = 0; k < 4; k++) txn(0, 1, 3'd2, 32'h40 + 32'(k * 4), $urandom, 1, 1, rx);
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 1) == 1)
        txn(0, 1, sf[$urandom_range(0, 2)], 32'h40 + 32'($urandom_range(0, 15)), $urandom, 1, 1, rx);
      else
        txn(0, 0, lf[$urandom_range(0, 4)], 32'h40 + 32'($urandom_range(0, 15)), 32'h0, 1, 1, rx);
    end

    // zero-wait-state instance
    txn(1, 1, 3'd2, 32'h0, 32'h1, 1, 1, rx);
    txn(1, 0, 3'd2, 32'h0, 32'h0, 1, 1, rx);
    txn(1, 0, 3'd0, 32'h0, 32'h0, 1, 1, rx);

    // reset during WAIT abandons the store
    txn(0, 1, 3'd2, 32'h20, 32'h0, 1, 1, rx);
    txn(0, 0, 3'd2, 32'h10, 32'h0, 1, 1, rx);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'd2;
    req_addr[0] = 32'h20; req_wdata[0] = 32'hA5A5A5A5;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    chk("pre_rst_ready", 32'(req_ready[0]), 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", 32'(req_ready[0]), 1);
    chk("async_rst_valid", 32'(rsp_valid[0]), 0);
    chk("async_rst_rdata", rsp_rdata[0], 0);
    chk("async_rst_err", 32'(rsp_err[0]), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    txn(0, 0, 3'd2, 32'h20, 32'h0, 1, 1, rx);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
